ask_uart_tx_p: RTL and testbench

Parametrised ASK-modulated UART transmitter: the next generation of the team's simple ASK UART TX. It buffers characters in an internal FIFO and serialises each one as an asynchronous frame: start bit, DATA_BITS data bits LSB first, optional parity, then 1 or 2 stop bits. Each line bit is then mapped onto the 2-bit ASK drive code. It sits between the register/CPU write path and the ASK line driver, and adds generic width/depth, parity, stop-bit selection, break generation, a registered glitch-free ASK output and status strobes.

---
 rtl/ask_uart_pkg.sv | 49 ++++
 rtl/ask_uart_fifo.sv | 73 +++++++
 rtl/ask_uart_tx_p.sv | 218 +++++++++++++++++++++
 tb/tb_ask_uart_tx_p.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ask_uart_pkg.sv
// Shared types, codes and helpers for the ASK-modulated UART transmitter.
package ask_uart_pkg;

    localparam int unsigned DIV_W      = 16;
    localparam int unsigned MIN_CLKDIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    localparam logic [1:0] ASK_MARK     = 2'b00;
    localparam logic [1:0] ASK_SPACE_LO = 2'b01;
    localparam logic [1:0] ASK_SPACE_HI = 2'b11;

    // Bit period actually used: short divisors are stretched to the minimum.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] clkdiv);
        return (clkdiv < DIV_W'(MIN_CLKDIV)) ? DIV_W'(MIN_CLKDIV) : clkdiv;
    endfunction

    // Space is split into two low/high quarter pairs so the carrier stays glitch-free.
    function automatic logic [1:0] ask_encode(input logic              line,
                                              input logic [DIV_W-1:0] p,
                                              input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0] q;
        logic [DIV_W-1:0] h;
        q = div >> 2;
        h = div >> 1;
        if (line) begin
            return ASK_MARK;
        end
        if ((p <= q) || ((p > h) && (p <= DIV_W'(h + q)))) begin
            return ASK_SPACE_LO;
        end
        return ASK_SPACE_HI;
    endfunction

endpackage

// File: rtl/ask_uart_fifo.sv
// First-word-fall-through character FIFO with registered level/full/overflow.
module ask_uart_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_BITS-1:0]   rd_data_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_ok_c;
    logic                 rd_ok_c;

    assign empty_c   = (level_q == '0);
    assign rd_data_c = mem_q[rptr_q];
    assign level     = level_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

    // A write into a full FIFO is still accepted when a pop frees a slot that cycle.
    always_comb begin
        rd_ok_c    = rd_en && !empty_c;
        wr_ok_c    = wr_en && (!full_q || rd_ok_c);
        overflow_d = wr_en && !wr_ok_c;
        wptr_d     = wr_ok_c ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d     = rd_ok_c ? rptr_q + PTR_W'(1) : rptr_q;
        case ({wr_ok_c, rd_ok_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/ask_uart_tx_p.sv
// Parametrised UART transmitter: FIFO-buffered framing, parity, break, ASK line encoding.
module ask_uart_tx_p
    import ask_uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   fifo_in,
    input  logic                   fifo_write,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_full,
    output logic                   fifo_overflow,
    input  logic [15:0]            clkdiv,
    input  logic [1:0]             parity_mode,
    input  logic                   two_stop,
    input  logic                   send_break,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   baudclk,
    output logic                   tx,
    output logic [1:0]             ask_tx
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     p_q, p_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q, par_d;
    logic                 two_q, two_d;
    logic                 brk_q, brk_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_q, baud_d;
    logic [1:0]           ask_q, ask_d;

    logic                 pop_c;
    logic                 load_c;
    logic                 last_c;
    logic [DIV_W-1:0]     p_next_c;
    logic                 fifo_empty_c;
    logic [DATA_BITS-1:0] fifo_data_c;
    parity_e              pmode_c;

    ask_uart_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (fifo_in),
        .wr_en     (fifo_write),
        .rd_en     (pop_c),
        .rd_data_c (fifo_data_c),
        .empty_c   (fifo_empty_c),
        .level     (fifo_level),
        .full      (fifo_full),
        .overflow  (fifo_overflow)
    );

    assign pmode_c  = parity_e'(parity_mode);
    assign last_c   = (p_q == div_q);
    assign p_next_c = last_c ? DIV_W'(1) : p_q + DIV_W'(1);

    // Next-state, frame sequencing and registered output values.
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        two_d    = two_q;
        brk_d    = brk_q;
        done_d   = 1'b0;
        load_c   = 1'b0;
        pop_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (send_break) begin
                    state_d = ST_BREAK;
                    div_d   = eff_div(clkdiv);
                    p_d     = DIV_W'(1);
                end else if (!fifo_empty_c) begin
                    load_c = 1'b1;
                end
            end
            ST_START: begin
                p_d = p_next_c;
                if (last_c) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                p_d = p_next_c;
                if (last_c) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                p_d = p_next_c;
                if (last_c) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                p_d = p_next_c;
                if (last_c) begin
                    // The mark bit closing a break is always single and never reports done.
                    if (brk_q || !two_q || (bit_q != '0)) begin
                        done_d = !brk_q;
                        brk_d  = 1'b0;
                        if (!send_break && !fifo_empty_c) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = BIT_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                p_d = p_next_c;
                if (last_c && !send_break) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    brk_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame configuration is captured only here, so mid-frame changes wait a frame.
        if (load_c) begin
            pop_c    = 1'b1;
            state_d  = ST_START;
            p_d      = DIV_W'(1);
            div_d    = eff_div(clkdiv);
            bit_d    = '0;
            sh_d     = fifo_data_c;
            par_en_d = (pmode_c == PAR_EVEN) || (pmode_c == PAR_ODD);
            par_d    = (^fifo_data_c) ^ (pmode_c == PAR_ODD);
            two_d    = two_stop;
            brk_d    = 1'b0;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_BREAK:  tx_d = 1'b0;
            ST_DATA:   tx_d = sh_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
        baud_d = busy_d && (p_d == DIV_W'(1));
        ask_d  = ask_encode(tx_q, p_q, div_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            p_q      <= DIV_W'(1);
            div_q    <= DIV_W'(MIN_CLKDIV);
            bit_q    <= '0;
            sh_q     <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            two_q    <= 1'b0;
            brk_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            baud_q   <= 1'b0;
            ask_q    <= ASK_MARK;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            two_q    <= two_d;
            brk_q    <= brk_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            baud_q   <= baud_d;
            ask_q    <= ask_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
    assign baudclk = baud_q;
    assign ask_tx  = ask_q;

endmodule

// File: tb/tb_ask_uart_tx_p.sv
// Scoreboard bench for ask_uart_tx_p: expected frames are queued by the stimulus, a line monitor checks them.
module tb_ask_uart_tx_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  fifo_in;
    logic        fifo_write;
    logic [2:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_overflow;
    logic [15:0] clkdiv;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        send_break;
    logic        busy;
    logic        tx_done;
    logic        baudclk;
    logic        tx;
    logic [1:0]  ask_tx;

    ask_uart_tx_p #(
        .DATA_BITS (8),
        .DEPTH     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_in       (fifo_in),
        .fifo_write    (fifo_write),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow),
        .clkdiv        (clkdiv),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .send_break    (send_break),
        .busy          (busy),
        .tx_done       (tx_done),
        .baudclk       (baudclk),
        .tx            (tx),
        .ask_tx        (ask_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        bit          done;
        bit          chain;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Hand-computed ASK space codes per phase (index = p-1).
    logic [1:0] ask4  [4]  = '{2'b01, 2'b11, 2'b01, 2'b11};
    logic [1:0] ask8  [8]  = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
    logic [1:0] ask16 [16] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    int         lvl_tab [6] = '{1, 1, 2, 3, 4, 4};
    logic [7:0] burst   [6] = '{8'hA1, 8'h3C, 8'hFF, 8'h00, 8'h96, 8'h5A};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            if (n_err <= 40) begin
                $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
            end
        end
    endtask

    function automatic exp_t mk(input logic [7:0] ch, input bit has_par, input bit par_bit,
                                input int nstop, input int div, input bit chain);
        exp_t e;
        int   n;
        e.bits = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            e.bits[n] = ch[i];
            n = n + 1;
        end
        if (has_par) begin
            e.bits[n] = par_bit;
            n = n + 1;
        end
        for (int s = 0; s < nstop; s++) begin
            e.bits[n] = 1'b1;
            n = n + 1;
        end
        e.nbits = n;
        e.div   = div;
        e.done  = 1'b1;
        e.chain = chain;
        return e;
    endfunction

    function automatic exp_t mk_break(input int nspace, input int div, input bit chain);
        exp_t e;
        e.bits         = '0;
        e.bits[nspace] = 1'b1;
        e.nbits        = nspace + 1;
        e.div          = div;
        e.done         = 1'b0;
        e.chain        = chain;
        return e;
    endfunction

    function automatic logic [1:0] exp_ask(input exp_t e, input int c);
        int b;
        int p;
        b = c / e.div;
        p = c % e.div;
        if (e.bits[b]) return 2'b00;
        case (e.div)
            4:       return ask4[p];
            8:       return ask8[p];
            16:      return ask16[p];
            default: return 2'bxx;
        endcase
    endfunction

    // Line monitor: a falling tx edge begins the next expected frame.
    exp_t cur;
    int   k = 0;
    bit   in_frame = 1'b0;
    logic prev_tx = 1'b1;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            k        = 0;
            prev_tx  = 1'b1;
        end else begin
            if (in_frame) begin
                if (k == cur.div * cur.nbits) begin
                    chk("ask_last", 32'(ask_tx), 32'(exp_ask(cur, k - 1)));
                    chk("tx_done_end", 32'(tx_done), 32'(cur.done));
                    chk("next_start_tx", 32'(tx), 32'(!cur.chain));
                    chk("busy_end", 32'(busy), 32'(cur.chain));
                    in_frame = 1'b0;
                end else begin
                    chk("ask", 32'(ask_tx), 32'(exp_ask(cur, k - 1)));
                    chk("tx_bit", 32'(tx), 32'(cur.bits[k / cur.div]));
                    chk("baudclk", 32'(baudclk), 32'((k % cur.div) == 0));
                    chk("tx_done_mid", 32'(tx_done), 32'(0));
                    chk("busy_mid", 32'(busy), 32'(1));
                    k++;
                end
            end
            if (!in_frame && (prev_tx === 1'b1) && (tx === 1'b0)) begin
                chk("frame_expected", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0) begin
                    cur      = sb.pop_front();
                    in_frame = 1'b1;
                    chk("busy_start", 32'(busy), 32'(1));
                    chk("baud_start", 32'(baudclk), 32'(1));
                    k = 1;
                end
            end
            prev_tx = tx;
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 32'(n < budget), 32'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic write_one(input logic [7:0] ch);
        fifo_in    = ch;
        fifo_write = 1'b1;
        @(negedge clk);
        fifo_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        fifo_in     = 8'h00;
        fifo_write  = 1'b0;
        clkdiv      = 16'd8;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        send_break  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_level", 32'(fifo_level), 32'(0));
        chk("rst_full", 32'(fifo_full), 32'(0));
        chk("rst_overflow", 32'(fifo_overflow), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_tx_done", 32'(tx_done), 32'(0));
        chk("rst_baudclk", 32'(baudclk), 32'(0));
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_ask", 32'(ask_tx), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0x55 with first-character latency
        sb.push_back(mk(8'h55, 1'b0, 1'b0, 1, 8, 1'b0));
        fifo_in    = 8'h55;
        fifo_write = 1'b1;
        @(negedge clk);
        fifo_write = 1'b0;
        chk("lat_level1", 32'(fifo_level), 32'(1));
        chk("lat_tx_idle", 32'(tx), 32'(1));
        @(negedge clk);
        chk("lat_start_tx", 32'(tx), 32'(0));
        chk("lat_busy", 32'(busy), 32'(1));
        chk("lat_level0", 32'(fifo_level), 32'(0));
        @(negedge clk);
        chk("lat_ask", 32'(ask_tx), 32'(2'b01));
        wait_idle(200);

        // even parity + two stop, 0x07: parity bit 1
        parity_mode = 2'b01;
        two_stop    = 1'b1;
        sb.push_back(mk(8'h07, 1'b1, 1'b1, 2, 8, 1'b0));
        write_one(8'h07);
        wait_idle(300);

        // odd parity, one stop, 0x07: parity bit 0
        parity_mode = 2'b10;
        two_stop    = 1'b0;
        sb.push_back(mk(8'h07, 1'b1, 1'b0, 1, 8, 1'b0));
        write_one(8'h07);
        wait_idle(300);

        // mode 11 means no parity
        parity_mode = 2'b11;
        sb.push_back(mk(8'hF0, 1'b0, 1'b0, 1, 8, 1'b0));
        write_one(8'hF0);
        wait_idle(300);
        parity_mode = 2'b00;

        // burst of six into a depth-4 FIFO; the sixth is dropped
        clkdiv = 16'd4;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(burst[i], 1'b0, 1'b0, 1, 4, i < 4));
        end
        for (int i = 0; i < 6; i++) begin
            fifo_in    = burst[i];
            fifo_write = 1'b1;
            @(negedge clk);
            chk("burst_level", 32'(fifo_level), 32'(lvl_tab[i]));
            chk("burst_full", 32'(fifo_full), 32'(i >= 4));
            chk("burst_overflow", 32'(fifo_overflow), 32'(i == 5));
        end
        fifo_write = 1'b0;
        @(negedge clk);
        chk("overflow_pulse_end", 32'(fifo_overflow), 32'(0));
        wait_idle(400);

        // divider change mid-frame applies from the next frame
        clkdiv = 16'd8;
        sb.push_back(mk(8'h81, 1'b0, 1'b0, 1, 8, 1'b1));
        sb.push_back(mk(8'h42, 1'b0, 1'b0, 1, 16, 1'b0));
        fifo_in    = 8'h81;
        fifo_write = 1'b1;
        @(negedge clk);
        fifo_in = 8'h42;
        @(negedge clk);
        fifo_write = 1'b0;
        repeat (20) @(negedge clk);
        clkdiv = 16'd16;
        wait_idle(600);

        // divider below minimum stretches to 4
        clkdiv = 16'd2;
        sb.push_back(mk(8'hC3, 1'b0, 1'b0, 1, 4, 1'b0));
        write_one(8'hC3);
        wait_idle(200);

        // break held 30 cycles with a character already queued
        clkdiv = 16'd8;
        sb.push_back(mk_break(4, 8, 1'b1));
        sb.push_back(mk(8'h3A, 1'b0, 1'b0, 1, 8, 1'b0));
        send_break = 1'b1;
        fifo_in    = 8'h3A;
        fifo_write = 1'b1;
        @(negedge clk);
        fifo_write = 1'b0;
        chk("break_level", 32'(fifo_level), 32'(1));
        repeat (29) @(negedge clk);
        chk("break_level_held", 32'(fifo_level), 32'(1));
        send_break = 1'b0;
        wait_idle(300);

        // asynchronous reset in the middle of a data bit
        sb.push_back(mk(8'h5A, 1'b0, 1'b0, 1, 8, 1'b1));
        sb.push_back(mk(8'h11, 1'b0, 1'b0, 1, 8, 1'b0));
        fifo_in    = 8'h5A;
        fifo_write = 1'b1;
        @(negedge clk);
        fifo_in = 8'h11;
        @(negedge clk);
        fifo_write = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 32'(1));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_tx", 32'(tx), 32'(1));
        chk("mid_rst_ask", 32'(ask_tx), 32'(0));
        chk("mid_rst_level", 32'(fifo_level), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_tx", 32'(tx), 32'(1));
        chk("post_rst_level", 32'(fifo_level), 32'(0));
        chk("post_rst_ask", 32'(ask_tx), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
